// File: rtl/semaforo_sensor_cond.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_sensor_cond
// Description : Input conditioning in front of the traffic-light controller.
//               It synchronises and debounces four raw asynchronous field
//               inputs (street sensors A/B, parade button P, release button R).
//               It delivers clean levels for TA/TB and single-cycle pulses
//               for P/R.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SYNC_STAGES      synchroniser depth per input (>= 2)
//   DEBOUNCE_CYCLES  consecutive cycles a new synced value must hold (>= 1)
// Ports
//   clk      in   system clock, all state on rising edge
//   rst_n    in   asynchronous active-low reset
//   ta_raw   in   raw street-A sensor (asynchronous)
//   tb_raw   in   raw street-B sensor (asynchronous)
//   p_raw    in   raw parade-mode button (asynchronous)
//   r_raw    in   raw parade-release button (asynchronous)
//   ta       out  debounced level of ta_raw
//   tb       out  debounced level of tb_raw
//   p_pulse  out  one-cycle pulse on debounced rising edge of p_raw
//   r_pulse  out  one-cycle pulse on debounced rising edge of r_raw
//   p_mode   out  (PARADE_HOLD_EN only) set by p_pulse, cleared by r_pulse
// Configuration
//   PARADE_HOLD_EN  when defined, adds the p_mode output and its hold logic
// ============================================================================
module semaforo_sensor_cond #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ta_raw,
  input  logic tb_raw,
  input  logic p_raw,
  input  logic r_raw,
  output logic ta,
  output logic tb,
  output logic p_pulse,
  output logic r_pulse
`ifdef PARADE_HOLD_EN
  ,
  output logic p_mode
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order: 0 = A sensor, 1 = B sensor, 2 = parade, 3 = release
  logic [3:0] raw_vec;
  logic [3:0] filt;
  logic [3:2] rise;

  assign raw_vec = {r_raw, p_raw, tb_raw, ta_raw};

  for (genvar i = 0; i < 4; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   level;
    logic                   s;

    assign s       = sync[SYNC_STAGES-1];
    assign filt[i] = level;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync  <= '0;
        cnt   <= '0;
        level <= 1'b0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], raw_vec[i]};
        if (s == level) begin
          // Any excursion shorter than the debounce window is forgotten here.
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          level <= s;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    // Button channels need to know, one edge early, that the filtered level
    // is about to rise so the pulse lands in the same cycle as the level.
    if (i >= 2) begin : g_edge
      assign rise[i] = s & ~level & (cnt == CNT_MAX);
    end
  end

  assign ta = filt[0];
  assign tb = filt[1];

  // Release wins over parade when both would fire in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_pulse <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      p_pulse <= rise[2] & ~rise[3];
      r_pulse <= rise[3];
    end
  end

`ifdef PARADE_HOLD_EN
  // Follows the registered pulses, so it changes one cycle after them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_mode <= 1'b0;
    end else if (r_pulse) begin
      p_mode <= 1'b0;
    end else if (p_pulse) begin
      p_mode <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_semaforo_sensor_cond.sv
`default_nettype none
// ============================================================================
// Module      : tb_semaforo_sensor_cond
// Description : Self-checking bench for semaforo_sensor_cond with
//               SYNC_STAGES=2 and DEBOUNCE_CYCLES=4. A window-based reference
//               pushes expected outputs on every clock edge. These are popped
//               and compared on the following falling edge. Directed checks
//               pin the spec latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_semaforo_sensor_cond;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HL   = SYNC + DEB;

  logic clk;
  logic rst_n;
  logic ta_raw, tb_raw, p_raw, r_raw;
  logic ta, tb, p_pulse, r_pulse;
`ifdef PARADE_HOLD_EN
  logic p_mode;
`endif

  semaforo_sensor_cond #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ta_raw (ta_raw),
    .tb_raw (tb_raw),
    .p_raw  (p_raw),
    .r_raw  (r_raw),
    .ta     (ta),
    .tb     (tb),
    .p_pulse(p_pulse),
    .r_pulse(r_pulse)
`ifdef PARADE_HOLD_EN
    ,
    .p_mode (p_mode)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int p_cnt  = 0;

  // Expected {ta, tb, p_pulse, r_pulse, p_mode}
  logic [4:0] sb_q[$];

  // Reference state: raw-sample history per channel, filtered levels, pulses
  logic [HL-1:0] m_hist[4];
  logic [3:0]    m_f;
  logic          m_p, m_r, m_pm;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  // A level flips once the DEB most recent synchronised samples (raw samples
  // SYNC..SYNC+DEB-1 edges old) all disagree with the current level.
  task automatic model_edge();
    logic [3:0] raw;
    logic [3:0] upd;
    logic       rise_p, rise_r;
    raw = {r_raw, p_raw, tb_raw, ta_raw};
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) m_hist[c] = '0;
      m_f  = '0;
      m_p  = 1'b0;
      m_r  = 1'b0;
      m_pm = 1'b0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        m_hist[c] = {m_hist[c][HL-2:0], raw[c]};
        upd[c] = 1'b1;
        for (int j = SYNC; j < HL; j++)
          if (m_hist[c][j] == m_f[c]) upd[c] = 1'b0;
      end
      if (m_r)      m_pm = 1'b0;
      else if (m_p) m_pm = 1'b1;
      rise_p = upd[2] & ~m_f[2];
      rise_r = upd[3] & ~m_f[3];
      m_p = rise_p & ~rise_r;
      m_r = rise_r;
      m_f = m_f ^ upd;
    end
    sb_q.push_back({m_f[0], m_f[1], m_p, m_r, m_pm});
  endtask

  task automatic step();
    logic [4:0] e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cycle++;
    if (sb_q.size() == 0) begin
      check("sb_empty", 8'd0, 8'd1);
    end else begin
      e = sb_q.pop_front();
      check("ta", {7'd0, ta}, {7'd0, e[4]});
      check("tb", {7'd0, tb}, {7'd0, e[3]});
      check("p_pulse", {7'd0, p_pulse}, {7'd0, e[2]});
      check("r_pulse", {7'd0, r_pulse}, {7'd0, e[1]});
`ifdef PARADE_HOLD_EN
      check("p_mode", {7'd0, p_mode}, {7'd0, e[0]});
`endif
    end
    if (p_pulse === 1'b1) p_cnt++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_raw(input logic a, input logic b, input logic p, input logic r);
    ta_raw = a;
    tb_raw = b;
    p_raw  = p;
    r_raw  = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    set_raw(1, 1, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    // 1. Reset with all raw inputs high
    check("rst_ta", {7'd0, ta}, 8'd0);
    check("rst_tb", {7'd0, tb}, 8'd0);
    check("rst_p", {7'd0, p_pulse}, 8'd0);
    check("rst_r", {7'd0, r_pulse}, 8'd0);
    run(3);
    rst_n = 1'b1;
    run(5);
    check("rst_lat_ta_early", {7'd0, ta}, 8'd0);
    run(1);
    check("rst_lat_ta", {7'd0, ta}, 8'd1);
    check("rst_lat_tb", {7'd0, tb}, 8'd1);
    check("rst_lat_r_prio", {7'd0, r_pulse}, 8'd1);
    check("rst_lat_p_supp", {7'd0, p_pulse}, 8'd0);
    set_raw(0, 0, 0, 0);
    run(10);

    // 2. Level latency, both directions
    ta_raw = 1'b1;
    run(5);
    check("lvl_rise_early", {7'd0, ta}, 8'd0);
    run(1);
    check("lvl_rise", {7'd0, ta}, 8'd1);
    ta_raw = 1'b0;
    run(5);
    check("lvl_fall_early", {7'd0, ta}, 8'd1);
    run(1);
    check("lvl_fall", {7'd0, ta}, 8'd0);
    run(4);

    // 3. Glitch rejection then acceptance
    tb_raw = 1'b1;
    run(3);
    tb_raw = 1'b0;
    run(8);
    check("glitch_tb", {7'd0, tb}, 8'd0);
    tb_raw = 1'b1;
    run(4);
    tb_raw = 1'b0;
    run(1);
    check("accept_tb_early", {7'd0, tb}, 8'd0);
    run(1);
    check("accept_tb", {7'd0, tb}, 8'd1);
    run(10);
    check("accept_tb_back", {7'd0, tb}, 8'd0);

    // 4. Held parade button gives exactly one pulse
    p_cnt = 0;
    p_raw = 1'b1;
    run(5);
    check("pulse_early", {7'd0, p_pulse}, 8'd0);
    run(1);
    check("pulse_at_5", {7'd0, p_pulse}, 8'd1);
    run(1);
    check("pulse_width", {7'd0, p_pulse}, 8'd0);
    run(33);
    p_raw = 1'b0;
    run(12);
    check("pulse_count", p_cnt[7:0], 8'd1);

    // 5. Parade then simultaneous P+R: release wins
    p_raw = 1'b1;
    run(8);
    p_raw = 1'b0;
    run(8);
`ifdef PARADE_HOLD_EN
    check("pmode_set", {7'd0, p_mode}, 8'd1);
`endif
    p_raw = 1'b1;
    r_raw = 1'b1;
    run(6);
    check("prio_r", {7'd0, r_pulse}, 8'd1);
    check("prio_p", {7'd0, p_pulse}, 8'd0);
    run(1);
`ifdef PARADE_HOLD_EN
    check("pmode_clr", {7'd0, p_mode}, 8'd0);
`endif
    p_raw = 1'b0;
    r_raw = 1'b0;
    run(10);

    // 6. Asynchronous reset in the middle of a debounce count
    ta_raw = 1'b1;
    run(8);
    check("pre_rst_ta", {7'd0, ta}, 8'd1);
    tb_raw = 1'b1;
    run(4);
    #2 rst_n = 1'b0;
    #1;
    check("async_ta", {7'd0, ta}, 8'd0);
    check("async_tb", {7'd0, tb}, 8'd0);
    run(1);
    rst_n = 1'b1;
    run(5);
    check("post_rst_tb_early", {7'd0, tb}, 8'd0);
    run(1);
    check("post_rst_tb", {7'd0, tb}, 8'd1);
    check("post_rst_ta", {7'd0, ta}, 8'd1);
    set_raw(0, 0, 0, 0);
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
